// File: rtl/vga_scan_timing.sv
`default_nettype none
// ============================================================================
//  Module   : vga_scan_timing
//  Purpose  : VGA raster timing generator. Produces pixel coordinates for the
//             renderer chain, takes the combined colour back in the same cycle,
//             and registers colour together with HS/VS/BLANK_N so every pin
//             leaves on the same clock edge. A frame-start strobe marks (0,0)
//             so upstream logic can update shape parameters.
//  Ports    : i_clk, i_rst_n (sync, active-low), i_en (advance / freeze)
//             i_pix_R/G/B   colour for the current o_VGA_X/o_VGA_Y
//             o_VGA_X/Y     current visible coordinate (0 outside active)
//             o_active      current position is visible (combinational)
//             o_VGA_R/G/B, o_VGA_HS, o_VGA_VS, o_VGA_BLANK_N  registered pins
//             o_VGA_SYNC_N  tied low
//             o_frame_start one-cycle strobe while (0,0) is issued
//  Revision : 1.0  initial release
// ============================================================================
module vga_scan_timing #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FRONT  = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FRONT  = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_en,
  input  logic [7:0]  i_pix_R,
  input  logic [7:0]  i_pix_G,
  input  logic [7:0]  i_pix_B,
  output logic [10:0] o_VGA_X,
  output logic [10:0] o_VGA_Y,
  output logic        o_active,
  output logic [7:0]  o_VGA_R,
  output logic [7:0]  o_VGA_G,
  output logic [7:0]  o_VGA_B,
  output logic        o_VGA_HS,
  output logic        o_VGA_VS,
  output logic        o_VGA_BLANK_N,
  output logic        o_VGA_SYNC_N,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Phase boundaries as 11-bit constants so all comparisons are width-matched.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  // Counters are 11 bits wide; larger timings cannot be represented.
  if (H_TOTAL > 2047) begin : g_h_total_check
    $error("vga_scan_timing: H_TOTAL exceeds 2047");
  end
  if (V_TOTAL > 2047) begin : g_v_total_check
    $error("vga_scan_timing: V_TOTAL exceeds 2047");
  end

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  function automatic phase_e h_phase_of(input logic [10:0] cnt);
    if (cnt < H_ACT_END)       return PH_ACTIVE;
    else if (cnt < H_SYNC_BEG) return PH_FRONT;
    else if (cnt < H_SYNC_END) return PH_SYNC;
    else                       return PH_BACK;
  endfunction

  function automatic phase_e v_phase_of(input logic [10:0] cnt);
    if (cnt < V_ACT_END)       return PH_ACTIVE;
    else if (cnt < V_SYNC_BEG) return PH_FRONT;
    else if (cnt < V_SYNC_END) return PH_SYNC;
    else                       return PH_BACK;
  endfunction

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  phase_e      h_phase_q, v_phase_q;
  logic [7:0]  r_q, g_q, b_q;
  logic        hs_q, vs_q, blank_n_q;
  logic        w_active;

  // Next position: the line counter wraps every H_TOTAL clocks and only then
  // is the frame counter allowed to step.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (i_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 11'd0;
        if (v_cnt_q == V_LAST) v_cnt_d = 11'd0;
        else                   v_cnt_d = v_cnt_q + 11'd1;
      end else begin
        h_cnt_d = h_cnt_q + 11'd1;
      end
    end
  end

  // Phase registers always describe the current counter values: they are
  // loaded from the phase of the next count, so they never lag by a cycle.
  assign w_active = (h_phase_q == PH_ACTIVE) && (v_phase_q == PH_ACTIVE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      h_cnt_q   <= 11'd0;
      v_cnt_q   <= 11'd0;
      h_phase_q <= h_phase_of(11'd0);
      v_phase_q <= v_phase_of(11'd0);
      r_q       <= 8'd0;
      g_q       <= 8'd0;
      b_q       <= 8'd0;
      blank_n_q <= 1'b0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
    end else if (i_en) begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      h_phase_q <= h_phase_of(h_cnt_d);
      v_phase_q <= v_phase_of(v_cnt_d);
      // Colour and syncs are captured on the same edge so the pins stay
      // mutually aligned one clock after the coordinate was issued.
      r_q       <= w_active ? i_pix_R : 8'd0;
      g_q       <= w_active ? i_pix_G : 8'd0;
      b_q       <= w_active ? i_pix_B : 8'd0;
      blank_n_q <= w_active;
      hs_q      <= (h_phase_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
      vs_q      <= (v_phase_q == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign o_active      = w_active;
  assign o_VGA_X       = w_active ? h_cnt_q : 11'd0;
  assign o_VGA_Y       = w_active ? v_cnt_q : 11'd0;
  assign o_frame_start = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0) && i_en;

  assign o_VGA_R       = r_q;
  assign o_VGA_G       = g_q;
  assign o_VGA_B       = b_q;
  assign o_VGA_HS      = hs_q;
  assign o_VGA_VS      = vs_q;
  assign o_VGA_BLANK_N = blank_n_q;
  assign o_VGA_SYNC_N  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_timing.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_scan_timing
//  Purpose  : Self-checking bench for vga_scan_timing. Instance 0 uses a tiny
//             raster (15x11, SYNC_POL=1) so whole frames fit in a short run;
//             instance 1 uses the default 640x480 timing for line-level
//             checks. A position-index model predicts every output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_scan_timing;

  localparam int HA  [2] = '{8, 640};
  localparam int HF  [2] = '{2, 16};
  localparam int HS  [2] = '{3, 96};
  localparam int HB  [2] = '{2, 48};
  localparam int VA  [2] = '{6, 480};
  localparam int VF  [2] = '{1, 10};
  localparam int VS  [2] = '{2, 2};
  localparam int VB  [2] = '{2, 33};
  localparam bit POL [2] = '{1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        en;
  logic        rst_n [2];
  logic [7:0]  pR [2], pG [2], pB [2];
  logic [10:0] vx [2], vy [2];
  logic        act [2], hs [2], vs [2], bl [2], sn [2], fs [2];
  logic [7:0]  oR [2], oG [2], oB [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Renderer stand-in: colour is a pure function of the issued coordinate.
  assign pR[0] = vx[0][7:0] ^ 8'h5A;
  assign pG[0] = vy[0][7:0] ^ 8'hC3;
  assign pB[0] = 8'hA5;
  assign pR[1] = vx[1][7:0] ^ 8'h5A;
  assign pG[1] = vy[1][7:0] ^ 8'hC3;
  assign pB[1] = 8'hA5;

  vga_scan_timing #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1'b1)
  ) u_small (
    .i_clk(clk), .i_rst_n(rst_n[0]), .i_en(en),
    .i_pix_R(pR[0]), .i_pix_G(pG[0]), .i_pix_B(pB[0]),
    .o_VGA_X(vx[0]), .o_VGA_Y(vy[0]), .o_active(act[0]),
    .o_VGA_R(oR[0]), .o_VGA_G(oG[0]), .o_VGA_B(oB[0]),
    .o_VGA_HS(hs[0]), .o_VGA_VS(vs[0]), .o_VGA_BLANK_N(bl[0]),
    .o_VGA_SYNC_N(sn[0]), .o_frame_start(fs[0])
  );

  vga_scan_timing u_full (
    .i_clk(clk), .i_rst_n(rst_n[1]), .i_en(en),
    .i_pix_R(pR[1]), .i_pix_G(pG[1]), .i_pix_B(pB[1]),
    .o_VGA_X(vx[1]), .o_VGA_Y(vy[1]), .o_active(act[1]),
    .o_VGA_R(oR[1]), .o_VGA_G(oG[1]), .o_VGA_B(oB[1]),
    .o_VGA_HS(hs[1]), .o_VGA_VS(vs[1]), .o_VGA_BLANK_N(bl[1]),
    .o_VGA_SYNC_N(sn[1]), .o_frame_start(fs[1])
  );

  task automatic chk(input int d, input string name,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h expected %0h at t=%0t", d, name, got, exp, $time);
    end
  endtask

  // ---------------- model: a linear position index within the frame -------
  function automatic int htot(input int d); return HA[d] + HF[d] + HS[d] + HB[d]; endfunction
  function automatic int vtot(input int d); return VA[d] + VF[d] + VS[d] + VB[d]; endfunction
  function automatic int m_h(input int d, input int p); return p % htot(d); endfunction
  function automatic int m_v(input int d, input int p); return p / htot(d); endfunction
  function automatic bit m_act(input int d, input int p);
    return (m_h(d, p) < HA[d]) && (m_v(d, p) < VA[d]);
  endfunction
  function automatic bit m_hsync(input int d, input int p);
    return (m_h(d, p) >= HA[d] + HF[d]) && (m_h(d, p) < HA[d] + HF[d] + HS[d]);
  endfunction
  function automatic bit m_vsync(input int d, input int p);
    return (m_v(d, p) >= VA[d] + VF[d]) && (m_v(d, p) < VA[d] + VF[d] + VS[d]);
  endfunction

  int         pos [2];
  bit         val [2] = '{1'b0, 1'b0};
  logic [7:0] eR [2], eG [2], eB [2];
  logic       eBl [2], eHs [2], eVs [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        pos[d] <= 0;
        eR[d]  <= 8'h00;
        eG[d]  <= 8'h00;
        eB[d]  <= 8'h00;
        eBl[d] <= 1'b0;
        eHs[d] <= ~POL[d];
        eVs[d] <= ~POL[d];
        val[d] <= 1'b1;
      end else if (en) begin
        eR[d]  <= m_act(d, pos[d]) ? (8'(m_h(d, pos[d])) ^ 8'h5A) : 8'h00;
        eG[d]  <= m_act(d, pos[d]) ? (8'(m_v(d, pos[d])) ^ 8'hC3) : 8'h00;
        eB[d]  <= m_act(d, pos[d]) ? 8'hA5 : 8'h00;
        eBl[d] <= m_act(d, pos[d]);
        eHs[d] <= m_hsync(d, pos[d]) ? POL[d] : ~POL[d];
        eVs[d] <= m_vsync(d, pos[d]) ? POL[d] : ~POL[d];
        pos[d] <= (pos[d] + 1) % (htot(d) * vtot(d));
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset edge.
  always @(negedge clk) begin
    #2;
    for (int d = 0; d < 2; d++) begin
      if (val[d]) begin
        chk(d, "X",       32'(vx[d]),  m_act(d, pos[d]) ? 32'(m_h(d, pos[d])) : 32'd0);
        chk(d, "Y",       32'(vy[d]),  m_act(d, pos[d]) ? 32'(m_v(d, pos[d])) : 32'd0);
        chk(d, "active",  32'(act[d]), 32'(m_act(d, pos[d])));
        chk(d, "fstart",  32'(fs[d]),  32'((pos[d] == 0) && en));
        chk(d, "R",       32'(oR[d]),  32'(eR[d]));
        chk(d, "G",       32'(oG[d]),  32'(eG[d]));
        chk(d, "B",       32'(oB[d]),  32'(eB[d]));
        chk(d, "BLANK_N", 32'(bl[d]),  32'(eBl[d]));
        chk(d, "HS",      32'(hs[d]),  32'(eHs[d]));
        chk(d, "VS",      32'(vs[d]),  32'(eVs[d]));
        chk(d, "SYNC_N",  32'(sn[d]),  32'd0);
      end
    end
  end

  // ---------------- directed stimulus with hand-computed literals ----------
  int fs0_times[$];
  int rise1[$];
  bit prev_act1 = 1'b0;
  int hs1_low = 0, bl1_high = 0, hs1_first = -1, vs0_sync = 0;
  bit arm = 1'b0, done = 1'b0;
  int rst_cycle = -10;

  initial begin
    en = 1'b1;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    chk(1, "rst_HS", 32'(hs[1]), 32'd1);
    chk(1, "rst_VS", 32'(vs[1]), 32'd1);
    chk(1, "rst_BLANK_N", 32'(bl[1]), 32'd0);
    chk(1, "rst_RGB", {8'h00, oR[1], oG[1], oB[1]}, 32'd0);
    chk(1, "rst_XY", {5'd0, vx[1], 5'd0, vy[1]}, 32'd0);
    chk(1, "rst_active", 32'(act[1]), 32'd1);
    chk(0, "rst_HS_pol1", 32'(hs[0]), 32'd0);
    chk(0, "rst_VS_pol1", 32'(vs[0]), 32'd0);

    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    for (int c = 0; c < 1650; c++) begin
      if (c == 900) en = 1'b0;
      if (c == 910) en = 1'b1;
      if (c == rst_cycle + 1) rst_n[0] = 1'b1;
      if (arm) begin
        rst_n[0] = 1'b0;
        rst_cycle = c;
        arm = 1'b0;
        done = 1'b1;
      end
      #3;
      if (c == 0) begin
        chk(0, "first_fstart", 32'(fs[0]), 32'd1);
        chk(1, "first_fstart", 32'(fs[1]), 32'd1);
      end
      if (c < 800) begin
        if (hs[1] == 1'b0) begin
          hs1_low++;
          if (hs1_first < 0) hs1_first = c;
        end
        if (bl[1] == 1'b1) bl1_high++;
      end
      if (c < 165 && vs[0] == 1'b1) vs0_sync++;
      if (c < 900 && fs[0] == 1'b1) fs0_times.push_back(c);
      if (act[1] && !prev_act1) rise1.push_back(c);
      prev_act1 = act[1];
      if (c == 201) begin
        chk(1, "pix_R", 32'(oR[1]), 32'(8'hC8 ^ 8'h5A));
        chk(1, "pix_G", 32'(oG[1]), 32'(8'h00 ^ 8'hC3));
        chk(1, "pix_B", 32'(oB[1]), 32'h0A5);
      end
      if (c == 700) begin
        chk(1, "blank_RGB", {8'h00, oR[1], oG[1], oB[1]}, 32'd0);
        chk(1, "blank_pixB_nonzero_in", 32'(pB[1]), 32'h0A5);
      end
      if (c >= 900 && c <= 910) begin
        chk(1, "gate_X", 32'(vx[1]), 32'd100);
        chk(1, "gate_Y", 32'(vy[1]), 32'd1);
        chk(1, "gate_R", 32'(oR[1]), 32'(8'd99 ^ 8'h5A));
        chk(0, "gate_fstart", 32'(fs[0]), 32'd0);
        chk(1, "gate_fstart", 32'(fs[1]), 32'd0);
      end
      if (c == 911) begin
        chk(1, "resume_X", 32'(vx[1]), 32'd101);
        chk(1, "resume_R", 32'(oR[1]), 32'(8'd100 ^ 8'h5A));
      end
      if (c == rst_cycle) begin
        chk(0, "pre_rst_X", 32'(vx[0]), 32'd5);
        chk(0, "pre_rst_Y", 32'(vy[0]), 32'd4);
      end
      if (c == rst_cycle + 1) begin
        chk(0, "post_rst_XY", {5'd0, vx[0], 5'd0, vy[0]}, 32'd0);
        chk(0, "post_rst_fstart", 32'(fs[0]), 32'd1);
        chk(0, "post_rst_BLANK_N", 32'(bl[0]), 32'd0);
        chk(0, "post_rst_R", 32'(oR[0]), 32'd0);
        chk(0, "post_rst_HS", 32'(hs[0]), 32'd0);
      end
      if (!done && c > 1000 && act[0] && vx[0] == 11'd4 && vy[0] == 11'd4) arm = 1'b1;
      @(negedge clk);
    end

    chk(1, "hs_low_clocks", 32'(hs1_low), 32'd96);
    chk(1, "hs_first_low_cycle", 32'(hs1_first), 32'd657);
    chk(1, "blank_n_high_clocks", 32'(bl1_high), 32'd640);
    chk(0, "vs_sync_clocks", 32'(vs0_sync), 32'd30);
    chk(0, "fstart_count", 32'(fs0_times.size()), 32'd6);
    for (int i = 1; i < fs0_times.size(); i++)
      chk(0, "fstart_spacing", 32'(fs0_times[i] - fs0_times[i-1]), 32'd165);
    chk(1, "line_starts", 32'(rise1.size()), 32'd3);
    if (rise1.size() >= 3) begin
      chk(1, "line_period", 32'(rise1[1] - rise1[0]), 32'd800);
      chk(1, "gated_line_period", 32'(rise1[2] - rise1[1]), 32'd810);
    end
    chk(0, "midframe_reset_reached", 32'(done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_scan_timing.md
Name: vga_scan_timing

Overview:
- Generates VGA raster timing and pixel coordinates for the renderer chain.
- Drives o_VGA_X/o_VGA_Y into CircleRenderer and similar pixel renderers.
- Takes their combined colour back, and registers colour together with the HS/VS/BLANK_N/SYNC_N outputs so all pins stay aligned.
- Emits a frame-start strobe so upstream logic can update shape parameters during vertical blanking.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front-porch clocks
- H_SYNC, 96, horizontal sync-pulse clocks
- H_BACK, 48, horizontal back-porch clocks
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front-porch lines
- V_SYNC, 2, vertical sync-pulse lines
- V_BACK, 33, vertical back-porch lines
- SYNC_POL, 0, sync pulse level (0 = active-low pulses)

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  synchronous active-low reset
- i_en  in  1  advance scan when 1; freeze all state when 0
- i_pix_R  in  8  pixel colour red for the current o_VGA_X/o_VGA_Y
- i_pix_G  in  8  pixel colour green
- i_pix_B  in  8  pixel colour blue
- o_VGA_X  out  11  current column, 0..H_ACTIVE-1; 0 outside active
- o_VGA_Y  out  11  current row, 0..V_ACTIVE-1; 0 outside active
- o_active  out  1  current (h,v) is in the visible region (combinational, same cycle as X/Y)
- o_VGA_R  out  8  registered red
- o_VGA_G  out  8  registered green
- o_VGA_B  out  8  registered blue
- o_VGA_HS  out  1  registered horizontal sync
- o_VGA_VS  out  1  registered vertical sync
- o_VGA_BLANK_N  out  1  registered, 1 during visible pixels
- o_VGA_SYNC_N  out  1  tied 0
- o_frame_start  out  1  one-cycle pulse when h=0, v=0 is issued

Behaviour:
- Clock and reset: one clock i_clk; reset is synchronous and active-low, i_rst_n.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters (default 800).
  - v_cnt runs 0..V_TOTAL-1 (default 525).
  - v_cnt increments only when h_cnt wraps from H_TOTAL-1 to 0.
  - At h = H_TOTAL-1 and v = V_TOTAL-1, both wrap to 0.
- Horizontal phase FSM, derived from h_cnt; states in order:
  - ACTIVE: h < H_ACTIVE
  - FRONT: next H_FRONT clocks
  - SYNC: next H_SYNC clocks
  - BACK: remainder
- Vertical phases follow the same order and are derived from v_cnt.
- o_active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - o_VGA_X = o_active ? h_cnt : 0.
  - o_VGA_Y = o_active ? v_cnt : 0.
  - All three are combinational from the counters.
- Renderers return colour combinationally in the same cycle.
- Output register, captured on each enabled edge:
  - R/G/B ← o_active ? i_pix : 0.
  - BLANK_N ← o_active.
  - HS ← (h in SYNC) ? SYNC_POL : ~SYNC_POL.
  - VS ← (v in SYNC) ? SYNC_POL : ~SYNC_POL.
  - Latency: coordinate to pin = 1 clock; colour and syncs are always mutually aligned.
- o_frame_start: combinational, 1 when h_cnt==0 && v_cnt==0 && i_en.
- Width rules:
  - Counters are 11 bits.
  - The elaboration parameter check requires H_TOTAL and V_TOTAL ≤ 2047.
- Reset (i_rst_n=0 at an edge), applied regardless of i_en:
  - h_cnt = v_cnt = 0.
  - o_VGA_R/G/B = 0, o_VGA_BLANK_N = 0.
  - o_VGA_HS = o_VGA_VS = ~SYNC_POL.
  - Combinational outputs follow from the counters: o_VGA_X = o_VGA_Y = 0, o_active = 1.
  - o_frame_start = i_en.
  - Reset mid-line or mid-frame restarts at (0,0) on the next edge; there is no partial-frame completion.
- i_en=0:
  - Counters and output registers hold their values.
  - o_frame_start = 0.
  - Re-enable continues from the held position.

Test Plan:
- Reset values: hold i_rst_n=0 for 3 clocks → HS=VS=1, BLANK_N=0, RGB=0, X=Y=0. On release, o_frame_start=1 in the first cycle.
- Horizontal timing, defaults: one line → HS low for exactly 96 clocks, first low at the edge after h=656. BLANK_N high for 640 clocks. Line period is 800 clocks.
- Frame wrap: run to h=799, v=524 → next cycle h=0, v=0 and o_frame_start=1. Pulses are spaced exactly 420000 clocks apart. VS low for 1600 clocks starting after v=490.
- Colour path: drive i_pix = {X[7:0], Y[7:0], 8'hA5} → at the pin one clock later, R=prev X, G=prev Y, B=A5 while BLANK_N=1. RGB=0 throughout blanking even with i_pix nonzero.
- Enable gating: drop i_en for 10 clocks at h=100 → X stays 100, pins frozen, no frame_start. Resume continues at h=101 with total line length 810 clocks.
- Reset mid-frame: assert i_rst_n=0 for one clock at h=300, v=200 → next cycle h=0, v=0, outputs at reset values, then normal timing from line 0.
